// File: rtl/demux_seq_pkg.sv
// Shared types and constants for the demux select sequencer.
package demux_seq_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SEL_W  = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } seq_state_t;

    // Counter width for a 0..n-1 count, never narrower than one bit
    function automatic int unsigned DWELL_W(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dwell_counter.sv
// Per-slot dwell counter: counts 0..DWELL-1 while enabled and wraps.
module dwell_counter
    import demux_seq_pkg::*;
#(
    parameter int unsigned DWELL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic last
);

    localparam int unsigned W   = DWELL_W(DWELL);
    localparam logic [W-1:0] MAX = W'(DWELL - 1);

    logic [W-1:0] cnt;

    // Count while enabled, wrap on the last dwell cycle
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= last ? '0 : cnt + W'(1);
        end
    end

    assign last = (cnt == MAX);

endmodule

// File: rtl/demux_sel_sequencer.sv
// Serializes 4-bit frames onto the demux select/data pair, one slot per
// channel, each slot held DWELL cycles.
// Optional feature: define DEMUX_SEQ_BUF_EN for a one-entry prefetch buffer
// that allows back-to-back frames without an IDLE gap.
module demux_sel_sequencer
    import demux_seq_pkg::*;
#(
    parameter int unsigned DWELL = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NUM_CH-1:0] in_data,
    output logic [SEL_W-1:0]  A,
    output logic              din,
    output logic              frame_start,
    output logic              busy
);

    localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(NUM_CH - 1);

    seq_state_t        state, state_nx;
    logic [SEL_W-1:0]  slot, slot_nx;
    logic [NUM_CH-1:0] frame, frame_nx;
    logic              fresh, fresh_nx;
    logic              dwell_last, dwell_clr, dwell_en;
    logic              hs, frame_end;

`ifdef DEMUX_SEQ_BUF_EN
    logic [NUM_CH-1:0] buf_data, buf_data_nx;
    logic              buf_full, buf_full_nx;

    assign in_ready = !rst && !buf_full;
`else
    assign in_ready = !rst && (state == IDLE);
`endif

    assign hs        = in_valid && in_ready;
    assign frame_end = (state == SHIFT) && (slot == LAST_SLOT) && dwell_last;

    dwell_counter #(.DWELL(DWELL)) u_dwell (
        .clk  (clk),
        .rst  (rst),
        .en   (dwell_en),
        .clr  (dwell_clr),
        .last (dwell_last)
    );

    // Next-state: frame acceptance, slot stepping and end-of-frame reload
    always_comb begin
        state_nx    = state;
        slot_nx     = slot;
        frame_nx    = frame;
        fresh_nx    = 1'b0;
        dwell_clr   = 1'b0;
        dwell_en    = (state == SHIFT);
`ifdef DEMUX_SEQ_BUF_EN
        buf_data_nx = buf_data;
        buf_full_nx = buf_full;
`endif
        case (state)
            IDLE: begin
                if (hs) begin
                    state_nx  = SHIFT;
                    slot_nx   = '0;
                    frame_nx  = in_data;
                    fresh_nx  = 1'b1;
                    dwell_clr = 1'b1;
                end
            end
            SHIFT: begin
                if (dwell_last) begin
                    slot_nx = slot + SEL_W'(1);
                end
                if (frame_end) begin
`ifdef DEMUX_SEQ_BUF_EN
                    if (buf_full) begin
                        frame_nx    = buf_data;
                        buf_full_nx = 1'b0;
                        fresh_nx    = 1'b1;
                    end else if (hs) begin
                        frame_nx = in_data;
                        fresh_nx = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
`else
                    state_nx = IDLE;
`endif
                end
`ifdef DEMUX_SEQ_BUF_EN
                else if (hs) begin
                    buf_data_nx = in_data;
                    buf_full_nx = 1'b1;
                end
`endif
            end
            default: state_nx = IDLE;
        endcase
    end

    // State, frame register and registered demux drive
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            slot        <= '0;
            frame       <= '0;
            fresh       <= 1'b0;
            A           <= '0;
            din         <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nx;
            slot        <= slot_nx;
            frame       <= frame_nx;
            fresh       <= fresh_nx;
            A           <= (state == SHIFT) ? slot : '0;
            din         <= (state == SHIFT) && frame[slot];
            frame_start <= (state == SHIFT) && fresh;
            busy        <= (state == SHIFT);
        end
    end

`ifdef DEMUX_SEQ_BUF_EN
    // Prefetch buffer holding the next frame while one is in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_data <= '0;
            buf_full <= 1'b0;
        end else begin
            buf_data <= buf_data_nx;
            buf_full <= buf_full_nx;
        end
    end
`endif

endmodule

// File: tb/tb_demux_sel_sequencer.sv
// Bench for demux_sel_sequencer: three instances (DWELL=4,2,1) share the
// stimulus; a frame-position model predicts every output each cycle.
module tb_demux_sel_sequencer;

`ifdef DEMUX_SEQ_BUF_EN
    localparam bit BUF = 1'b1;
`else
    localparam bit BUF = 1'b0;
`endif
    localparam int HN = 1024;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] in_data;

    logic       rdy_o  [3];
    logic [1:0] a_o    [3];
    logic       din_o  [3];
    logic       fs_o   [3];
    logic       busy_o [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned DWV = (g == 0) ? 4 : ((g == 1) ? 2 : 1);
        demux_sel_sequencer #(.DWELL(DWV)) dut (
            .clk         (clk),
            .rst         (rst),
            .in_valid    (in_valid),
            .in_ready    (rdy_o[g]),
            .in_data     (in_data),
            .A           (a_o[g]),
            .din         (din_o[g]),
            .frame_start (fs_o[g]),
            .busy        (busy_o[g])
        );
    end

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit started = 1'b0;

    // Model: per instance, whether a frame is active and how many cycles in
    bit         m_act [3];
    int         m_t   [3];
    logic [3:0] m_cur [3];
    logic [3:0] m_buf [3];
    bit         m_hb  [3];
    bit         m_hs  [3];
    logic [1:0] e_a   [3];
    logic       e_din [3];
    logic       e_fs  [3];
    logic       e_busy[3];

    logic [1:0] h_a    [3][HN];
    logic       h_din  [3][HN];
    logic       h_fs   [3][HN];
    logic       h_busy [3][HN];
    logic       h_rdy  [3][HN];

    function automatic int dwell_of(input int i);
        return (i == 0) ? 4 : ((i == 1) ? 2 : 1);
    endfunction

    function automatic logic m_ready(input int i);
        if (rst) return 1'b0;
        return BUF ? !m_hb[i] : !m_act[i];
    endfunction

    task automatic chk(input string name, input int i, input logic [7:0] act,
                       input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s inst%0d cyc%0d: got %0d expected %0d",
                     name, i, cyc, act, exp);
        end
    endtask

    // Model update on each edge from the inputs presented before it
    always @(posedge clk) begin
        cyc = cyc + 1;
        started = 1'b1;
        for (int i = 0; i < 3; i++) begin
            int  d;
            bit  hs;
            d = dwell_of(i);
            if (!rst && m_act[i]) begin
                e_a[i]    = 2'(m_t[i] / d);
                e_din[i]  = m_cur[i][m_t[i] / d];
                e_fs[i]   = (m_t[i] == 0);
                e_busy[i] = 1'b1;
            end else begin
                e_a[i]    = 2'd0;
                e_din[i]  = 1'b0;
                e_fs[i]   = 1'b0;
                e_busy[i] = 1'b0;
            end
            hs = in_valid && m_ready(i);
            m_hs[i] = hs;
            if (rst) begin
                m_act[i] = 1'b0;
                m_hb[i]  = 1'b0;
            end else if (!m_act[i]) begin
                if (hs) begin
                    m_act[i] = 1'b1;
                    m_t[i]   = 0;
                    m_cur[i] = in_data;
                end
            end else if (m_t[i] == 4 * d - 1) begin
                m_t[i] = 0;
                if (m_hb[i]) begin
                    m_cur[i] = m_buf[i];
                    m_hb[i]  = 1'b0;
                end else if (hs) begin
                    m_cur[i] = in_data;
                end else begin
                    m_act[i] = 1'b0;
                end
            end else begin
                m_t[i] = m_t[i] + 1;
                if (hs) begin
                    m_buf[i] = in_data;
                    m_hb[i]  = 1'b1;
                end
            end
        end
    end

    // Compare every output against the model away from the active edge
    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 3; i++) begin
                chk("A", i, 8'(a_o[i]), 8'(e_a[i]));
                chk("din", i, 8'(din_o[i]), 8'(e_din[i]));
                chk("frame_start", i, 8'(fs_o[i]), 8'(e_fs[i]));
                chk("busy", i, 8'(busy_o[i]), 8'(e_busy[i]));
                chk("in_ready", i, 8'(rdy_o[i]), 8'(m_ready(i)));
                if (cyc < HN) begin
                    h_a[i][cyc]    = a_o[i];
                    h_din[i][cyc]  = din_o[i];
                    h_fs[i][cyc]   = fs_o[i];
                    h_busy[i][cyc] = busy_o[i];
                    h_rdy[i][cyc]  = rdy_o[i];
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle offer to all instances; returns the handshake edge index
    task automatic send_all(input logic [3:0] d, output int hc);
        in_valid = 1'b1;
        in_data  = d;
        hc = cyc + 1;
        step();
        in_valid = 1'b0;
    endtask

    // Hold the current frame until instance 1 accepts it
    task automatic wait_hs1(input string name, output int hcyc);
        bit seen;
        seen = 1'b0;
        hcyc = 0;
        for (int k = 0; k < 60 && !seen; k++) begin
            step();
            if (m_hs[1]) begin
                seen = 1'b1;
                hcyc = cyc;
            end
        end
        chk(name, 1, 8'(seen), 8'd1);
    endtask

    initial begin
        int hc, h1, h2, h3, bc;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 4'd0;
        step();
        step();
        rst = 1'b0;

        // Quiet idle after reset
        repeat (20) step();
        for (int i = 0; i < 3; i++) begin
            chk("idle_ready", i, 8'(h_rdy[i][cyc - 1]), 8'd1);
            chk("idle_busy", i, 8'(h_busy[i][cyc - 10]), 8'd0);
        end

        // Single frame 1011
        send_all(4'b1011, hc);
        repeat (25) step();
        chk("t1_fs_hs", 0, 8'(h_fs[0][hc]), 8'd0);
        chk("t1_fs", 0, 8'(h_fs[0][hc + 1]), 8'd1);
        chk("t1_fs_once", 0, 8'(h_fs[0][hc + 2]), 8'd0);
        chk("t1_a0", 0, 8'(h_a[0][hc + 4]), 8'd0);
        chk("t1_a1", 0, 8'(h_a[0][hc + 5]), 8'd1);
        chk("t1_a2", 0, 8'(h_a[0][hc + 9]), 8'd2);
        chk("t1_a3", 0, 8'(h_a[0][hc + 16]), 8'd3);
        chk("t1_d0", 0, 8'(h_din[0][hc + 1]), 8'd1);
        chk("t1_d1", 0, 8'(h_din[0][hc + 8]), 8'd1);
        chk("t1_d2", 0, 8'(h_din[0][hc + 9]), 8'd0);
        chk("t1_d3", 0, 8'(h_din[0][hc + 13]), 8'd1);
        chk("t1_end_busy", 0, 8'(h_busy[0][hc + 17]), 8'd0);
        chk("t1_end_din", 0, 8'(h_din[0][hc + 17]), 8'd0);
        chk("t1_dw1_d2", 2, 8'(h_din[2][hc + 3]), 8'd0);
        chk("t1_dw1_d3", 2, 8'(h_din[2][hc + 4]), 8'd1);

        // Held in_valid: 0001 then 1000 (and 0110 when buffered)
        in_valid = 1'b1;
        in_data  = 4'b0001;
        wait_hs1("t2_hs1", h1);
        in_data = 4'b1000;
        wait_hs1("t2_hs2", h2);
        if (BUF) begin
            in_data = 4'b0110;
            wait_hs1("t2_hs3", h3);
        end else begin
            h3 = 0;
        end
        in_valid = 1'b0;
        repeat (40) step();
        chk("t2_fs1", 1, 8'(h_fs[1][h1 + 1]), 8'd1);
        chk("t2_rdy_low", 1, 8'(h_rdy[1][h1 + 7]), 8'd0);
        chk("t2_rdy_back", 1, 8'(h_rdy[1][h1 + 8]), 8'd1);
        if (BUF) begin
            chk("t2_gap", 1, 8'(h2 - h1), 8'd1);
            chk("t2_fs2", 1, 8'(h_fs[1][h1 + 9]), 8'd1);
            chk("t2_nogap", 1, 8'(h_busy[1][h1 + 9]), 8'd1);
            chk("t2_stall", 1, 8'(h3 - h1), 8'd9);
            chk("t2_rdy_full", 1, 8'(h_rdy[1][h1 + 1]), 8'd0);
            chk("t2_f2_s1", 1, 8'(h_din[1][h1 + 13]), 8'd0);
            chk("t2_f2_s3", 1, 8'(h_din[1][h1 + 15]), 8'd1);
        end else begin
            chk("t2_gap", 1, 8'(h2 - h1), 8'd9);
            chk("t2_idle_cyc", 1, 8'(h_busy[1][h1 + 9]), 8'd0);
            chk("t2_busy_pre", 1, 8'(h_busy[1][h1 + 8]), 8'd1);
            chk("t2_fs2", 1, 8'(h_fs[1][h1 + 10]), 8'd1);
            chk("t2_f2_s1", 1, 8'(h_din[1][h2 + 4]), 8'd0);
            chk("t2_f2_s3", 1, 8'(h_din[1][h2 + 7]), 8'd1);
        end

        // Reset while instance 0 shows A=2
        send_all(4'b1111, hc);
        while (cyc < hc + 9) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (10) step();
        chk("t3_pre_a", 0, 8'(h_a[0][hc + 9]), 8'd2);
        chk("t3_rdy_rst", 0, 8'(h_rdy[0][hc + 9]), 8'd0);
        chk("t3_a", 0, 8'(h_a[0][hc + 10]), 8'd0);
        chk("t3_din", 0, 8'(h_din[0][hc + 10]), 8'd0);
        chk("t3_busy", 0, 8'(h_busy[0][hc + 10]), 8'd0);
        chk("t3_no_resume", 0, 8'(h_busy[0][hc + 14]), 8'd0);
        chk("t3_rdy_after", 0, 8'(h_rdy[0][hc + 10]), 8'd1);

        // DWELL=1 frame 0101
        send_all(4'b0101, hc);
        repeat (20) step();
        bc = 0;
        for (int k = 0; k <= 8; k++) bc += int'(h_busy[2][hc + k]);
        chk("t4_busy_cnt", 2, 8'(bc), 8'd4);
        chk("t4_d0", 2, 8'(h_din[2][hc + 1]), 8'd1);
        chk("t4_d1", 2, 8'(h_din[2][hc + 2]), 8'd0);
        chk("t4_d2", 2, 8'(h_din[2][hc + 3]), 8'd1);
        chk("t4_d3", 2, 8'(h_din[2][hc + 4]), 8'd0);
        chk("t4_a1", 2, 8'(h_a[2][hc + 2]), 8'd1);
        chk("t4_a3", 2, 8'(h_a[2][hc + 4]), 8'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
